// File: rtl/g4_table_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : g4_table_search_ctrl
// Description : Sequencer/arbiter for one G4 rule table. Round-robin arbitrates
//               lookup requests against entry updates on the table's single
//               index port, and walks lookups along the next_index chain until
//               a hit, the chain end or the hop limit.
// Revision    : 1.0 - initial release
// ============================================================================
module g4_table_search_ctrl #(
    parameter int                       TABLE_ENTRY_SIZE = 29,
    parameter int                       INDEX_BIT_LEN    = 11,
    parameter int                       PACKET_BIT_LEN   = 104,
    parameter int                       ENTRY_DATA_WIDTH = 98,
    parameter int                       MAX_HOPS         = 8,
    parameter logic [INDEX_BIT_LEN-1:0] NULL_INDEX       = {INDEX_BIT_LEN{1'b1}}
) (
    input  logic                        clk,
    input  logic                        rst_n,
    // lookup request
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [PACKET_BIT_LEN-1:0]   req_tuple,
    input  logic [INDEX_BIT_LEN-1:0]    req_head,
    // lookup response
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_hit,
    output logic [INDEX_BIT_LEN-1:0]    rsp_ruleID,
    output logic [3:0]                  rsp_hops,
    output logic                        rsp_ovf,
    // entry update
    input  logic                        upd_valid,
    output logic                        upd_ready,
    input  logic [INDEX_BIT_LEN-1:0]    upd_index,
    input  logic [ENTRY_DATA_WIDTH-1:0] upd_data,
    output logic                        upd_err,
    // table port
    output logic                        tbl_we,
    output logic [ENTRY_DATA_WIDTH-1:0] tbl_din,
    output logic [INDEX_BIT_LEN:0]      tbl_index,
    output logic [PACKET_BIT_LEN-1:0]   tbl_tuple,
    input  logic                        tbl_match,
    input  logic [INDEX_BIT_LEN-1:0]    tbl_ruleID,
    input  logic [INDEX_BIT_LEN-1:0]    tbl_next_index
);

    localparam logic [INDEX_BIT_LEN-1:0] c_last_idx = INDEX_BIT_LEN'(TABLE_ENTRY_SIZE);
    localparam logic [3:0]               c_max_hops = 4'(MAX_HOPS);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_EVAL  = 3'd2,
        ST_WR       = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    // registered state and outputs
    state_t                      r_state;
    logic                        r_rr_last;     // 0: lookup granted last, 1: update granted last
    logic [3:0]                  r_hops;
    logic                        r_req_ready;
    logic                        r_upd_ready;
    logic                        r_upd_err;
    logic                        r_rsp_valid;
    logic                        r_rsp_hit;
    logic [INDEX_BIT_LEN-1:0]    r_rsp_ruleID;
    logic [3:0]                  r_rsp_hops;
    logic                        r_rsp_ovf;
    logic                        r_tbl_we;
    logic [ENTRY_DATA_WIDTH-1:0] r_tbl_din;
    logic [INDEX_BIT_LEN:0]      r_tbl_index;
    logic [PACKET_BIT_LEN-1:0]   r_tbl_tuple;

    // next-state values
    state_t                      w_state_nxt;
    logic                        w_rr_last_nxt;
    logic [3:0]                  w_hops_nxt;
    logic                        w_req_ready_nxt;
    logic                        w_upd_ready_nxt;
    logic                        w_upd_err_nxt;
    logic                        w_rsp_valid_nxt;
    logic                        w_rsp_hit_nxt;
    logic [INDEX_BIT_LEN-1:0]    w_rsp_ruleID_nxt;
    logic [3:0]                  w_rsp_hops_nxt;
    logic                        w_rsp_ovf_nxt;
    logic                        w_tbl_we_nxt;
    logic [ENTRY_DATA_WIDTH-1:0] w_tbl_din_nxt;
    logic [INDEX_BIT_LEN:0]      w_tbl_index_nxt;
    logic [PACKET_BIT_LEN-1:0]   w_tbl_tuple_nxt;

    // arbitration
    logic w_grant_lookup;
    logic w_grant_update;
    logic w_handshake_busy;
    logic w_chain_end;

    // Round-robin: with both valid, grant the type that did not win last time.
    assign w_grant_lookup   = req_valid & (~upd_valid | r_rr_last);
    assign w_grant_update   = upd_valid & (~req_valid | ~r_rr_last);
    // A ready pulse still on the port means the requester has not yet seen its
    // handshake; re-arbitrating now would grant the same command twice.
    assign w_handshake_busy = r_req_ready | r_upd_ready;
    assign w_chain_end      = (tbl_next_index == NULL_INDEX) || (tbl_next_index > c_last_idx);

    // Next-state and next-output decode; every register holds unless overridden.
    always_comb begin
        w_state_nxt      = r_state;
        w_rr_last_nxt    = r_rr_last;
        w_hops_nxt       = r_hops;
        w_req_ready_nxt  = 1'b0;
        w_upd_ready_nxt  = 1'b0;
        w_upd_err_nxt    = 1'b0;
        w_rsp_valid_nxt  = r_rsp_valid;
        w_rsp_hit_nxt    = r_rsp_hit;
        w_rsp_ruleID_nxt = r_rsp_ruleID;
        w_rsp_hops_nxt   = r_rsp_hops;
        w_rsp_ovf_nxt    = r_rsp_ovf;
        w_tbl_we_nxt     = 1'b0;
        w_tbl_din_nxt    = '0;
        w_tbl_index_nxt  = r_tbl_index;
        w_tbl_tuple_nxt  = r_tbl_tuple;

        case (r_state)
            ST_IDLE: begin
                w_tbl_index_nxt = '0;
                w_tbl_tuple_nxt = '0;
                if (!w_handshake_busy) begin
                    if (w_grant_lookup) begin
                        w_req_ready_nxt = 1'b1;
                        w_rr_last_nxt   = 1'b0;
                        w_hops_nxt      = 4'd0;
                        w_tbl_tuple_nxt = req_tuple;
                        if (req_head > c_last_idx) begin
                            // head outside the table: answer a miss without any read
                            w_state_nxt      = ST_RESP;
                            w_rsp_valid_nxt  = 1'b1;
                            w_rsp_hit_nxt    = 1'b0;
                            w_rsp_ruleID_nxt = '0;
                            w_rsp_hops_nxt   = 4'd0;
                            w_rsp_ovf_nxt    = 1'b0;
                        end else begin
                            w_state_nxt     = ST_RD_ISSUE;
                            w_tbl_index_nxt = {1'b0, req_head};
                        end
                    end else if (w_grant_update) begin
                        w_upd_ready_nxt = 1'b1;
                        w_rr_last_nxt   = 1'b1;
                        if (upd_index > c_last_idx) begin
                            w_upd_err_nxt = 1'b1;
                        end else begin
                            w_state_nxt     = ST_WR;
                            w_tbl_we_nxt    = 1'b1;
                            w_tbl_index_nxt = {1'b0, upd_index};
                            w_tbl_din_nxt   = upd_data;
                        end
                    end
                end
            end

            ST_RD_ISSUE: begin
                // index is on the port this cycle; the result arrives next cycle
                w_hops_nxt  = r_hops + 4'd1;
                w_state_nxt = ST_RD_EVAL;
            end

            ST_RD_EVAL: begin
                if (tbl_match) begin
                    w_state_nxt      = ST_RESP;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_hit_nxt    = 1'b1;
                    w_rsp_ruleID_nxt = tbl_ruleID;
                    w_rsp_hops_nxt   = r_hops;
                    w_rsp_ovf_nxt    = 1'b0;
                end else if (w_chain_end) begin
                    w_state_nxt      = ST_RESP;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_hit_nxt    = 1'b0;
                    w_rsp_ruleID_nxt = '0;
                    w_rsp_hops_nxt   = r_hops;
                    w_rsp_ovf_nxt    = 1'b0;
                end else if (r_hops == c_max_hops) begin
                    w_state_nxt      = ST_RESP;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_hit_nxt    = 1'b0;
                    w_rsp_ruleID_nxt = '0;
                    w_rsp_hops_nxt   = r_hops;
                    w_rsp_ovf_nxt    = 1'b1;
                end else begin
                    w_state_nxt     = ST_RD_ISSUE;
                    w_tbl_index_nxt = {1'b0, tbl_next_index};
                end
            end

            ST_WR: begin
                w_state_nxt     = ST_IDLE;
                w_tbl_index_nxt = '0;
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt      = ST_IDLE;
                    w_rsp_valid_nxt  = 1'b0;
                    w_rsp_hit_nxt    = 1'b0;
                    w_rsp_ruleID_nxt = '0;
                    w_rsp_hops_nxt   = 4'd0;
                    w_rsp_ovf_nxt    = 1'b0;
                    w_tbl_index_nxt  = '0;
                    w_tbl_tuple_nxt  = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rr_last    <= 1'b0;
            r_hops       <= 4'd0;
            r_req_ready  <= 1'b0;
            r_upd_ready  <= 1'b0;
            r_upd_err    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_hit    <= 1'b0;
            r_rsp_ruleID <= '0;
            r_rsp_hops   <= 4'd0;
            r_rsp_ovf    <= 1'b0;
            r_tbl_we     <= 1'b0;
            r_tbl_din    <= '0;
            r_tbl_index  <= '0;
            r_tbl_tuple  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_last    <= w_rr_last_nxt;
            r_hops       <= w_hops_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_upd_ready  <= w_upd_ready_nxt;
            r_upd_err    <= w_upd_err_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_hit    <= w_rsp_hit_nxt;
            r_rsp_ruleID <= w_rsp_ruleID_nxt;
            r_rsp_hops   <= w_rsp_hops_nxt;
            r_rsp_ovf    <= w_rsp_ovf_nxt;
            r_tbl_we     <= w_tbl_we_nxt;
            r_tbl_din    <= w_tbl_din_nxt;
            r_tbl_index  <= w_tbl_index_nxt;
            r_tbl_tuple  <= w_tbl_tuple_nxt;
        end
    end

    assign req_ready  = r_req_ready;
    assign upd_ready  = r_upd_ready;
    assign upd_err    = r_upd_err;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_hit    = r_rsp_hit;
    assign rsp_ruleID = r_rsp_ruleID;
    assign rsp_hops   = r_rsp_hops;
    assign rsp_ovf    = r_rsp_ovf;
    assign tbl_we     = r_tbl_we;
    assign tbl_din    = r_tbl_din;
    assign tbl_index  = r_tbl_index;
    assign tbl_tuple  = r_tbl_tuple;

endmodule
`default_nettype wire

// File: tb/tb_g4_table_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_g4_table_search_ctrl
// Description : Directed self-checking bench for g4_table_search_ctrl with a
//               registered-read table model (key in entry[31:0], ruleID in
//               entry[42:32], next_index in entry[53:43]).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_g4_table_search_ctrl;

    localparam int IW = 11;
    localparam int PW = 104;
    localparam int DW = 98;
    localparam int TS = 29;
    localparam logic [IW-1:0] NUL = 11'h7FF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready;
    logic [PW-1:0] req_tuple;
    logic [IW-1:0] req_head;
    logic          rsp_valid, rsp_ready, rsp_hit, rsp_ovf;
    logic [IW-1:0] rsp_ruleID;
    logic [3:0]    rsp_hops;
    logic          upd_valid, upd_ready, upd_err;
    logic [IW-1:0] upd_index;
    logic [DW-1:0] upd_data;
    logic          tbl_we;
    logic [DW-1:0] tbl_din;
    logic [IW:0]   tbl_index;
    logic [PW-1:0] tbl_tuple;
    logic          tbl_match;
    logic [IW-1:0] tbl_ruleID, tbl_next_index;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    g4_table_search_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_tuple(req_tuple), .req_head(req_head),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_ruleID(rsp_ruleID),
        .rsp_hops(rsp_hops), .rsp_ovf(rsp_ovf),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index), .upd_data(upd_data),
        .upd_err(upd_err),
        .tbl_we(tbl_we), .tbl_din(tbl_din), .tbl_index(tbl_index), .tbl_tuple(tbl_tuple),
        .tbl_match(tbl_match), .tbl_ruleID(tbl_ruleID), .tbl_next_index(tbl_next_index)
    );

    // table model: registered read, write port shared with a bench backdoor
    logic [DW-1:0] mem [0:TS];
    logic          bk_we = 1'b0;
    logic [4:0]    bk_idx = '0;
    logic [DW-1:0] bk_dat = '0;
    int            we_cnt = 0;

    // Table write and registered compare/read.
    always @(posedge clk) begin
        if (tbl_we && tbl_index <= 12'(TS)) mem[tbl_index[4:0]] <= tbl_din;
        else if (bk_we)                     mem[bk_idx]         <= bk_dat;
        if (tbl_index <= 12'(TS)) begin
            tbl_match      <= (mem[tbl_index[4:0]][31:0] == tbl_tuple[31:0]);
            tbl_ruleID     <= mem[tbl_index[4:0]][42:32];
            tbl_next_index <= mem[tbl_index[4:0]][53:43];
        end else begin
            tbl_match      <= 1'b0;
            tbl_ruleID     <= '0;
            tbl_next_index <= NUL;
        end
        if (tbl_we) we_cnt <= we_cnt + 1;
    end

    // Run-away guard.
    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mk(input logic [31:0] key, input logic [10:0] rule,
                                         input logic [10:0] nxt);
        return {44'd0, nxt, rule, key};
    endfunction

    function automatic logic [PW-1:0] tup(input logic [31:0] key);
        return {8'hA5, 64'h0123_4567_89AB_CDEF, key};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bk_write(input int idx, input logic [DW-1:0] dat);
        bk_idx = 5'(idx);
        bk_dat = dat;
        bk_we  = 1'b1;
        @(negedge clk);
        bk_we  = 1'b0;
    endtask

    task automatic do_lookup(input string tag, input logic [10:0] head, input logic [31:0] key,
                             input logic exp_hit, input logic [10:0] exp_rule,
                             input logic [3:0] exp_hops, input logic exp_ovf);
        int n;
        int lat;
        lat       = (exp_hops == 4'd0) ? 1 : 2 * int'(exp_hops) + 1;
        req_head  = head;
        req_tuple = tup(key);
        req_valid = 1'b1;
        @(negedge clk);
        chk({tag, ".req_ready"}, 128'(req_ready), 128'(1));
        chk({tag, ".tuple"}, 128'(tbl_tuple), 128'(tup(key)));
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, 128'(n), 128'(lat));
        chk({tag, ".rsp"}, 128'({rsp_hit, rsp_ruleID, rsp_hops, rsp_ovf}),
            128'({exp_hit, exp_rule, exp_hops, exp_ovf}));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".rsp_clear"}, 128'({rsp_valid, rsp_hit, rsp_ruleID, rsp_hops, rsp_ovf}), 128'(0));
    endtask

    localparam logic [31:0] KA = 32'hAAAA_0003;
    localparam logic [31:0] KB = 32'hBBBB_0007;
    localparam logic [31:0] KC = 32'hCCCC_000C;
    localparam logic [31:0] KD = 32'hDDDD_0004;
    localparam logic [31:0] KM = 32'h1111_1111;

    initial begin
        int  n;
        int  w0;
        logic seen;
        rst_n = 1'b0;
        req_valid = 1'b0; req_tuple = '0; req_head = '0; rsp_ready = 1'b0;
        upd_valid = 1'b0; upd_index = '0; upd_data = '0;

        // preload: every entry a non-matching chain end
        for (int i = 0; i <= TS; i++) bk_write(i, mk(32'hFFFF_0000 | 32'(i), 11'(i), NUL));
        bk_write(3,  mk(KA, 11'h103, 11'd7));
        bk_write(7,  mk(KB, 11'h107, 11'd12));
        bk_write(12, mk(KC, 11'h10C, NUL));
        bk_write(5,  mk(32'h5555_0005, 11'h105, 11'd6));
        bk_write(6,  mk(32'h6666_0006, 11'h106, 11'd5));

        // reset state
        chk("rst.ctl", 128'({req_ready, upd_ready, rsp_valid, rsp_hit, rsp_ruleID, rsp_hops,
                             rsp_ovf, upd_err, tbl_we, tbl_index}), 128'(0));
        chk("rst.din", 128'(tbl_din), 128'(0));
        chk("rst.tuple", 128'(tbl_tuple), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // reset in the middle of a hop-limited walk
        req_head = 11'd5; req_tuple = tup(32'h0); req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1.inflight_tuple", 128'(tbl_tuple), 128'(tup(32'h0)));
        #2 rst_n = 1'b0;
        #1;
        chk("t1.async_ctl", 128'({req_ready, upd_ready, rsp_valid, rsp_hit, rsp_ruleID, rsp_hops,
                                  rsp_ovf, upd_err, tbl_we, tbl_index}), 128'(0));
        chk("t1.async_tuple", 128'(tbl_tuple), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("t1.no_rsp_after_reset", 128'(seen), 128'(0));

        // simultaneous request/update after reset: update wins first
        req_head = 11'd12; req_tuple = tup(KC); req_valid = 1'b1;
        upd_index = 11'd20; upd_data = mk(32'h2020_2020, 11'h120, NUL); upd_valid = 1'b1;
        @(negedge clk);
        chk("t5.upd_first", 128'({upd_ready, req_ready, tbl_we, tbl_index}),
            128'({1'b1, 1'b0, 1'b1, 12'd20}));
        chk("t5.upd_din", 128'(tbl_din), 128'(mk(32'h2020_2020, 11'h120, NUL)));
        upd_valid = 1'b0;
        @(negedge clk);
        chk("t5.wr_done", 128'({req_ready, tbl_we}), 128'(0));
        chk("t5.din_clear", 128'(tbl_din), 128'(0));
        @(negedge clk);
        chk("t5.req_second", 128'(req_ready), 128'(1));
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("t5.latency", 128'(n), 128'(3));
        upd_index = 11'd21; upd_data = mk(32'h2121_2121, 11'h121, NUL); upd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5.rsp_hold", 128'({rsp_valid, rsp_hit, rsp_ruleID, rsp_hops, rsp_ovf, upd_ready, tbl_we}),
                128'({1'b1, 1'b1, 11'h10C, 4'd1, 1'b0, 1'b0, 1'b0}));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("t5.rsp_done", 128'({rsp_valid, upd_ready, tbl_we}), 128'(0));
        @(negedge clk);
        chk("t5.upd_after_resp", 128'({upd_ready, tbl_we, tbl_index}), 128'({1'b1, 1'b1, 12'd21}));
        upd_valid = 1'b0;
        @(negedge clk);
        chk("t5.upd_we_off", 128'(tbl_we), 128'(0));

        // single hit, chains, hop limit, out-of-range head / next
        do_lookup("t2.hit1", 11'd3, KA, 1'b1, 11'h103, 4'd1, 1'b0);
        do_lookup("t3.hit3", 11'd3, KC, 1'b1, 11'h10C, 4'd3, 1'b0);
        do_lookup("t3.miss_end3", 11'd3, KM, 1'b0, 11'h0, 4'd3, 1'b0);
        bk_write(7, mk(KB, 11'h107, NUL));
        do_lookup("t3.miss_end2", 11'd3, KM, 1'b0, 11'h0, 4'd2, 1'b0);
        do_lookup("t4.loop_ovf", 11'd5, KM, 1'b0, 11'h0, 4'd8, 1'b1);
        do_lookup("t4.head_oob", 11'd31, KA, 1'b0, 11'h0, 4'd0, 1'b0);
        bk_write(12, mk(KC, 11'h10C, 11'd30));
        do_lookup("t4.next_oob", 11'd12, KM, 1'b0, 11'h0, 4'd1, 1'b0);

        // out-of-range update: error pulse, no write
        w0 = we_cnt;
        upd_index = 11'd30; upd_data = {DW{1'b1}}; upd_valid = 1'b1;
        @(negedge clk);
        chk("t6.err_pulse", 128'({upd_ready, upd_err, tbl_we}), 128'({1'b1, 1'b1, 1'b0}));
        upd_valid = 1'b0;
        @(negedge clk);
        chk("t6.err_clear", 128'({upd_ready, upd_err, tbl_we}), 128'(0));
        @(negedge clk);
        chk("t6.no_write", 128'(we_cnt), 128'(w0));

        // in-range update then lookup of the new contents
        upd_index = 11'd4; upd_data = mk(KD, 11'h1D4, NUL); upd_valid = 1'b1;
        @(negedge clk);
        chk("t6.wr", 128'({upd_ready, upd_err, tbl_we, tbl_index}), 128'({1'b1, 1'b0, 1'b1, 12'd4}));
        chk("t6.wr_din", 128'(tbl_din), 128'(mk(KD, 11'h1D4, NUL)));
        upd_valid = 1'b0;
        @(negedge clk);
        chk("t6.wr_off", 128'({tbl_we, tbl_index}), 128'(0));
        chk("t6.din_off", 128'(tbl_din), 128'(0));
        chk("t6.one_write", 128'(we_cnt), 128'(w0 + 1));
        do_lookup("t6.new_data", 11'd4, KD, 1'b1, 11'h1D4, 4'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
